mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit (MDU) for the EX stage of the MIPS32 pipeline.
- Decodes the R-type HI/LO group from Funct: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Runs a pipelined multiplier and an iterative restoring divider, and owns the HI/LO architectural registers.
- Raises stall_req to the hazard unit while a result is pending; the ALU handles all single-cycle ops.

Parameters:
- WIDTH, 32: operand and HI/LO width; must be even and >= 8.
- MUL_STAGES, 2: multiplier pipeline depth in cycles (1..4).
- DIV_ZERO_LO, all-ones of WIDTH: value written to LO on divide by zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  EX-stage instruction is an MDU op (Funct valid).
- Funct  in  6  instruction function field.
- flush  in  1  EX-stage flush; aborts the op in flight.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- rd_data  out  WIDTH  MFHI/MFLO result, combinational from HI/LO.
- busy  out  1  multiply or divide in flight.
- stall_req  out  1  pipeline must hold EX this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: synchronous and active-high. Reset has priority over every other input. On reset, hi = lo = 0, busy = 0, state = IDLE, and the multiplier pipe valid bits clear. Reset mid-operation discards the operation.
- Funct encoding:
  - 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - Any other Funct with start = 1 is a no-op. For mul/div, signed = ~Funct[0].
- Accept rule: an op is accepted when start = 1, flush = 0 and the state is IDLE.
- stall_req is high when start = 1 and either of these holds:
  - busy = 1, for any MDU op.
  - The state is IDLE but the op is MFHI or MFLO and a write is due this cycle; this cannot occur by construction, so stall_req equals start & busy.
- MTHI/MTLO: write A to hi/lo at the next edge. Single cycle; never busy.
- MFHI/MFLO: rd_data = hi or lo combinationally. rd_data = 0 for any other Funct.
- States:
  - IDLE: no operation pending.
  - MUL: MULT/MULTU accepted; busy = 1 for MUL_STAGES cycles. The 2·WIDTH product is written {hi, lo} at the edge ending cycle MUL_STAGES, then the state returns to IDLE.
  - DIV: DIV/DIVU accepted. Operands are latched and converted to magnitudes when signed. WIDTH iterations run at 1 bit/cycle, followed by 1 FIX cycle.
  - FIX: applies signs, writes lo = quotient and hi = remainder, then returns to IDLE. Total busy time is WIDTH+1 cycles.
- Signed division rules:
  - Quotient is negative iff sign(A) != sign(B).
  - Remainder takes the sign of A.
  - Quotient truncates toward zero.
- Divide-by-zero special case: B = 0 skips the iterations. The next edge writes hi = A and lo = DIV_ZERO_LO; busy lasts 1 cycle.
- Signed-overflow special case: MIN / -1 (signed) yields lo = MIN, hi = 0 through the normal path, with no trap.
- Flush:
  - Flush while busy returns the state to IDLE next edge and leaves hi/lo unchanged.
  - Flush together with start means nothing is accepted.
- Completion and a new start in the same cycle: busy is still 1, so the start is stalled and accepted in the following cycle. MFHI after a MULT therefore returns the new product.
- Width rules:
  - The product is the full 2·WIDTH result.
  - MULTU zero-extends and MULT sign-extends to WIDTH+1 bits before multiplying.

Decomposition:
- Package mdu_pkg holds:
  - The Funct localparams (FN_MFHI … FN_DIVU).
  - The state encoding (IDLE, MUL, DIV, FIX) as 2-bit localparams.
  - A function is_mdu_op(funct).
- One natural sub-module is mdu_divider: the iterative restoring core with start, dividend/divisor magnitudes, done, quotient and remainder. It is instantiated once.
- The multiplier is inferred inline as a product register followed by MUL_STAGES-1 shift registers.

Test Plan:
- Reset, then MTHI A=0x12345678, MTLO A=0x9ABCDEF0, then MFHI/MFLO -> rd_data = 0x12345678 / 0x9ABCDEF0, and stall_req stays 0 throughout.
- MULT A=0xFFFFFFFF (-1), B=0x00000002 -> busy for 2 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. MULTU with the same operands -> hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy for 33 cycles, then lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIVU A=100, B=7 -> lo = 14, hi = 2.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU A=5, B=0 -> busy 1 cycle, then hi = 5, lo = 0xFFFFFFFF.
- MULT issued, then MFLO with start = 1 on the next cycle -> stall_req = 1 until busy falls; MFLO then returns the product.
- DIV issued, flush asserted 10 cycles later -> busy = 0 next cycle with hi/lo unchanged. A separate run asserts reset at cycle 5 of a DIV -> hi = lo = 0 and busy = 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS32 multiply/divide unit: Funct codes,
// FSM state encoding and the HI/LO-group decode helper.
package mdu_pkg;

  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 2;

  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'b010011;
  localparam logic [FUNCT_W-1:0] FN_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FN_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'b011011;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_MUL  = 2'd1;
  localparam logic [STATE_W-1:0] S_DIV  = 2'd2;
  localparam logic [STATE_W-1:0] S_FIX  = 2'd3;

  // True for the eight HI/LO-group functions (0100xx and 0110xx).
  function automatic logic is_mdu_op(input logic [FUNCT_W-1:0] funct);
    return (funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done_c is high during the cycle whose closing edge retires the last bit.
module mdu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_c,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  assign done_c      = active_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = WIDTH'(shifted - {1'b0, dvs_q});
    fits     = (shifted >= {1'b0, dvs_q});
    active_d = active_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      quo_d    = dividend_i;
      rem_d    = '0;
      dvs_d    = divisor_i;
    end else if (abort_i) begin
      active_d = 1'b0;
    end else if (active_q) begin
      rem_d = fits ? trial : shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], fits};
      cnt_d = cnt_q + CNT_W'(1);
      if (done_c) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO: pipelined multiplier, iterative
// divider and MFHI/MFLO/MTHI/MTLO. WIDTH even and >= 8, MUL_STAGES in 1..4.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      MUL_STAGES  = 2,
  parameter logic [WIDTH-1:0] DIV_ZERO_LO = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               flush,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   rd_data,
  output logic               busy,
  output logic               stall_req,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               divz_q, divz_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               op_signed;
  logic               mul_go;
  logic               div_go;

  logic [PROD_W-1:0]  mul_a, mul_b, mul_p;
  logic [PROD_W-1:0]  prod_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] mv_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  assign op_signed = ~Funct[0];
  assign accept    = start & ~flush & (state_q == S_IDLE) & is_mdu_op(Funct);

  // Extending to 2*WIDTH gives the same low 2*WIDTH product bits as WIDTH+1.
  assign mul_a = op_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
  assign mul_b = op_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
  assign mul_p = mul_a * mul_b;

  assign mag_a = (op_signed & A[WIDTH-1]) ? -A : A;
  assign mag_b = (op_signed & B[WIDTH-1]) ? -B : B;

  // Product register followed by MUL_STAGES-1 retiming stages.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mv_q <= '0;
    end else begin
      mv_q[0] <= mul_go;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mv_q[i] <= mv_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      if (mul_go) begin
        prod_q[0] <= mul_p;
      end
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_go),
    .abort_i    (flush),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .done_c     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    divz_d  = divz_q;
    mul_go  = 1'b0;
    div_go  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (Funct)
            FN_MTHI: hi_d = A;
            FN_MTLO: lo_d = A;
            FN_MULT, FN_MULTU: begin
              mul_go  = 1'b1;
              state_d = S_MUL;
            end
            FN_DIV, FN_DIVU: begin
              // Zero divisor bypasses the iterations and goes straight to FIX.
              a_d     = A;
              q_neg_d = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              r_neg_d = op_signed & A[WIDTH-1];
              divz_d  = (B == '0);
              div_go  = (B != '0);
              state_d = (B == '0) ? S_FIX : S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mv_q[MUL_STAGES-1]) begin
          {hi_d, lo_d} = prod_q[MUL_STAGES-1];
          state_d      = S_IDLE;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (div_done) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          lo_d    = divz_q ? DIV_ZERO_LO : (q_neg_q ? -div_quo : div_quo);
          hi_d    = divz_q ? a_q : (r_neg_q ? -div_rem : div_rem);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      divz_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      divz_q  <= divz_d;
      busy_q  <= busy_d;
    end
  end

  // A new HI/LO write can only come from a busy op, so holding on busy suffices.
  assign stall_req = start & busy_q;
  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    case (Funct)
      FN_MFHI: rd_data = hi_q;
      FN_MFLO: rd_data = lo_q;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver pushes expected rd_data and HI/LO
// values from an architectural model; a negedge monitor pops and compares.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned MS = 2;

  logic          clk = 1'b0;
  logic          reset, start, flush;
  logic [5:0]    Funct;
  logic [W-1:0]  A, B, rd_data, hi, lo;
  logic          busy, stall_req;

  mdu_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct(Funct), .flush(flush),
    .A(A), .B(B), .rd_data(rd_data), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] rd_exp_q[$];
  logic [63:0] hl_exp_q[$];
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural effect of one op on HI/LO, using plain 64-bit arithmetic.
  function automatic void model_apply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (f)
      FN_MTHI: m_hi = a;
      FN_MTLO: m_lo = a;
      FN_MULT: begin
        p = sa * sb;
        {m_hi, m_lo} = p;
      end
      FN_MULTU: begin
        p = ua * ub;
        {m_hi, m_lo} = p;
      end
      FN_DIV: begin
        if (b == 0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      FN_DIVU: begin
        if (b == 0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else begin
          uq = ua / ub; ur = ua % ub;
          m_lo = uq[31:0]; m_hi = ur[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [5:0] f);
    if (f == FN_MFHI) return m_hi;
    if (f == FN_MFLO) return m_lo;
    return 32'h0;
  endfunction

  function automatic bit is_long(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic int busy_len(input logic [5:0] f, input logic [31:0] b);
    if ((f == FN_MULT) || (f == FN_MULTU)) return MS;
    if (b == 0) return 1;
    return W + 1;
  endfunction

  // Called just after a rising edge. mode 0: completes, 1: flushed, 2: reset.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int mode, output int stalls);
    rd_exp_q.push_back(rd_model(f));
    if (mode == 0) begin
      model_apply(f, a, b);
      if (is_long(f)) hl_exp_q.push_back({m_hi, m_lo});
    end else if (mode == 1) begin
      hl_exp_q.push_back({m_hi, m_lo});
    end else begin
      m_hi = '0; m_lo = '0;
      hl_exp_q.push_back(64'h0);
    end
    start = 1'b1; Funct = f; A = a; B = b;
    stalls = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall_req) break;
      stalls++;
    end
    if (stalls >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: stalled %0d cycles, limit 200", stalls);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: an accepted cycle presents rd_data; a falling busy presents HI/LO.
  always @(negedge clk) begin
    if (start && !stall_req && !flush && !reset) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_data: got %h with no expected value queued", rd_data);
      end else begin
        check("rd_data", 64'(rd_data), 64'(rd_exp_q.pop_front()));
      end
    end
    if (prev_busy && !busy) begin
      if (hl_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL hi_lo: got %h with no expected value queued", {hi, lo});
      end else begin
        check("hi_lo", {hi, lo}, hl_exp_q.pop_front());
      end
    end
    prev_busy = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] fl [9];

  initial begin
    int st, n;
    logic [5:0]  f;
    logic [31:0] a, b;
    fl = '{FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, 6'b100000};
    reset = 1'b1; start = 1'b0; flush = 1'b0; Funct = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_stall", 64'(stall_req), 64'h0);
    @(posedge clk); #1;

    // Moves to and from HI/LO never stall.
    issue(FN_MTHI, 32'h1234_5678, 32'h0, 0, st); check("mthi_stall", 64'(st), 64'h0);
    issue(FN_MTLO, 32'h9ABC_DEF0, 32'h0, 0, st); check("mtlo_stall", 64'(st), 64'h0);
    issue(FN_MFHI, 32'h0, 32'h0, 0, st);         check("mfhi_stall", 64'(st), 64'h0);
    issue(FN_MFLO, 32'h0, 32'h0, 0, st);         check("mflo_stall", 64'(st), 64'h0);
    check("mt_hi", 64'(hi), 64'h1234_5678);
    check("mt_lo", 64'(lo), 64'h9ABC_DEF0);

    issue(FN_MULT, 32'hFFFF_FFFF, 32'h2, 0, st); wait_idle(n);
    check("mult_busy", 64'(n), 64'(MS));
    check("mult_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(FN_MULTU, 32'hFFFF_FFFF, 32'h2, 0, st); wait_idle(n);
    check("multu_val", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    issue(FN_DIV, 32'hFFFF_FFF9, 32'h2, 0, st); wait_idle(n);
    check("div_busy", 64'(n), 64'(W + 1));
    check("div_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(FN_DIVU, 32'd100, 32'd7, 0, st); wait_idle(n);
    check("divu_val", {hi, lo}, {32'd2, 32'd14});
    issue(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, st); wait_idle(n);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(FN_DIVU, 32'd5, 32'd0, 0, st); wait_idle(n);
    check("divz_busy", 64'(n), 64'h1);
    check("divz_val", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

    // MFLO right behind a MULT holds until the product lands.
    issue(FN_MULT, 32'h0001_2345, 32'h0000_0100, 0, st);
    issue(FN_MFLO, 32'h0, 32'h0, 0, st);
    check("mflo_after_mult_stall", 64'(st), 64'(MS));

    // Flush ten cycles into a divide leaves HI/LO alone.
    issue(FN_DIV, 32'd1000, 32'd3, 1, st);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    @(posedge clk); #1;

    // Reset in cycle 5 of a divide.
    issue(FN_DIVU, 32'd1000, 32'd3, 2, st);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      f = fl[$urandom % 9];
      a = rnd_op();
      b = rnd_op();
      issue(f, a, b, 0, st);
      if (is_long(f) && ($urandom % 2 == 1)) begin
        wait_idle(n);
        check("rand_busy_len", 64'(n), 64'(busy_len(f, b)));
      end
    end
    wait_idle(n);
    repeat (2) @(posedge clk);
    check("rd_queue_drained", 64'(rd_exp_q.size()), 64'h0);
    check("hl_queue_drained", 64'(hl_exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
